// File: rtl/cpu_pkg.sv
// Shared CPU constants: next-PC mode encodings, reset vector and instruction field widths.
package cpu_pkg;
  localparam int PCM_W = 3;

  localparam logic [PCM_W-1:0] PCM_SEQ = 3'd0;
  localparam logic [PCM_W-1:0] PCM_BR  = 3'd1;
  localparam logic [PCM_W-1:0] PCM_J   = 3'd2;
  localparam logic [PCM_W-1:0] PCM_JAL = 3'd3;
  localparam logic [PCM_W-1:0] PCM_JR  = 3'd4;
  localparam logic [PCM_W-1:0] PCM_RET = 3'd5;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0020;

  localparam int IMM_W = 16;
  localparam int JT_W  = 26;
endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push on a full stack silently overwrites the oldest entry.
module ras_stack #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               tp_q, tp_d, tp_inc;
  logic [CW-1:0]               cnt_q, cnt_d;

  assign tp_inc  = tp_q + PW'(1);
  assign top_o   = mem_q[tp_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    tp_d  = tp_q;
    cnt_d = cnt_q;
    if (push_i) begin
      tp_d  = tp_inc;
      cnt_d = full_o ? cnt_q : cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      tp_d  = tp_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_i) mem_q[tp_inc] <= push_data_i;
  end
endmodule

// File: rtl/next_pc_unit.sv
// Architectural PC register and next-fetch-address selection with stall, redirect and a return stack.
module next_pc_unit
  import cpu_pkg::*;
#(
  parameter  int               WIDTH     = 32,
  parameter  logic [WIDTH-1:0] RESET_PC  = WIDTH'(RESET_PC_DEF),
  parameter  int               RAS_DEPTH = 4,
  localparam int               CW        = $clog2(RAS_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic [2:0]       mode,
  input  logic             br_taken,
  input  logic [IMM_W-1:0] imm16,
  input  logic [JT_W-1:0]  jtarget,
  input  logic [WIDTH-1:0] rs_val,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [CW-1:0]    ras_count,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ret_mismatch,
  output logic             illegal_mode
);
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             mm_q, mm_d, il_q, il_d;
  logic [WIDTH-1:0] br_tgt, j_tgt, ras_top;
  logic             push, pop;

  assign pc_plus4     = pc_q + WIDTH'(4);
  assign br_tgt       = pc_plus4 + {{(WIDTH-IMM_W-2){imm16[IMM_W-1]}}, imm16, 2'b00};
  assign j_tgt        = {pc_plus4[WIDTH-1:28], jtarget, 2'b00};
  assign pc           = pc_q;
  assign ret_mismatch = mm_q;
  assign illegal_mode = il_q;

  ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_plus4),
    .top_o       (ras_top),
    .count_o     (ras_count),
    .empty_o     (ras_empty),
    .full_o      (ras_full)
  );

  // Redirect and stall both block every side effect: no push, no pop, no pulses.
  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    mm_d = 1'b0;
    il_d = 1'b0;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (!stall) begin
      case (mode)
        PCM_SEQ: pc_d = pc_plus4;
        PCM_BR:  pc_d = br_taken ? br_tgt : pc_plus4;
        PCM_J:   pc_d = j_tgt;
        PCM_JAL: begin
          pc_d = j_tgt;
          push = 1'b1;
        end
        PCM_JR:  pc_d = rs_val;
        PCM_RET: begin
          if (ras_empty) begin
            pc_d = rs_val;
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
            mm_d = (ras_top != rs_val);
          end
        end
        default: begin
          pc_d = pc_plus4;
          il_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      mm_q <= 1'b0;
      il_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      mm_q <= mm_d;
      il_q <= il_d;
    end
  end
endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: queue-based reference model checked every cycle plus directed literal checks.
module tb_next_pc_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect, br_taken;
  logic [31:0] redirect_pc, rs_val;
  logic [2:0]  mode;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic [31:0] pc, pc_plus4;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ret_mismatch, illegal_mode;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  next_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mode(mode), .br_taken(br_taken),
    .imm16(imm16), .jtarget(jtarget), .rs_val(rs_val),
    .pc(pc), .pc_plus4(pc_plus4), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ret_mismatch(ret_mismatch), .illegal_mode(illegal_mode)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the RAS is a plain queue of link addresses, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_mm, m_il;
  bit          m_valid = 0;

  always @(posedge clk) begin : model
    logic [31:0] p4, jt, t;
    p4 = m_pc + 32'd4;
    jt = {p4[31:28], jtarget, 2'b00};
    m_mm = 0;
    m_il = 0;
    if (!rst_n) begin
      m_pc = 32'h0040_0020;
      m_ras.delete();
      m_valid = 1;
    end else if (redirect) begin
      m_pc = redirect_pc;
    end else if (!stall) begin
      case (mode)
        3'd0: m_pc = p4;
        3'd1: m_pc = br_taken ? p4 + ({{16{imm16[15]}}, imm16} << 2) : p4;
        3'd2: m_pc = jt;
        3'd3: begin
          m_ras.push_back(p4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
          m_pc = jt;
        end
        3'd4: m_pc = rs_val;
        3'd5: begin
          if (m_ras.size() > 0) begin
            t = m_ras.pop_back();
            m_mm = (t != rs_val);
            m_pc = t;
          end else m_pc = rs_val;
        end
        default: begin
          m_pc = p4;
          m_il = 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
      chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
      chk("ras_full", 32'(ras_full), 32'(m_ras.size() == 4));
      chk("ret_mismatch", 32'(ret_mismatch), 32'(m_mm));
      chk("illegal_mode", 32'(illegal_mode), 32'(m_il));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go(input logic [2:0] md);
    mode = md;
    redirect = 0;
    stall = 0;
    tick();
  endtask

  task automatic redir(input logic [31:0] a);
    redirect = 1;
    redirect_pc = a;
    tick();
    redirect = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0; stall = 0; redirect = 0; redirect_pc = '0; mode = PCM_SEQ;
    br_taken = 0; imm16 = '0; jtarget = '0; rs_val = '0;
    tick();
    chk("reset_pc", pc, 32'h0040_0020);
    chk("reset_cnt", 32'(ras_count), 0);
    rst_n = 1;
    go(PCM_SEQ); chk("seq1", pc, 32'h0040_0024);
    go(PCM_SEQ); chk("seq2", pc, 32'h0040_0028);
    go(PCM_SEQ); chk("seq3", pc, 32'h0040_002C);
    go(PCM_SEQ);

    // Branches: backward taken, not taken, and address wrap.
    imm16 = 16'hFFFE; br_taken = 1;
    go(PCM_BR); chk("br_back", pc, 32'h0040_002C);
    redir(32'h0040_0030);
    br_taken = 0;
    go(PCM_BR); chk("br_nt", pc, 32'h0040_0034);
    redir(32'hFFFF_FFF8);
    imm16 = 16'h7FFF; br_taken = 1;
    go(PCM_BR); chk("br_wrap", pc, 32'h0001_FFF8);
    br_taken = 0;

    // JAL / RET matched, then mismatched.
    redir(32'h0040_0040);
    jtarget = 26'h010_0010;
    go(PCM_JAL); chk("jal_pc", pc, 32'h0040_0040); chk("jal_cnt", 32'(ras_count), 1);
    rs_val = 32'h0040_0044;
    go(PCM_RET); chk("ret_pc", pc, 32'h0040_0044); chk("ret_cnt", 32'(ras_count), 0);
    chk("ret_nomm", 32'(ret_mismatch), 0);
    go(PCM_JAL); chk("jal2_pc", pc, 32'h0040_0040);
    rs_val = 32'h1234_5678;
    go(PCM_RET); chk("retmm_pc", pc, 32'h0040_0048); chk("retmm_pulse", 32'(ret_mismatch), 1);
    go(PCM_SEQ); chk("retmm_drop", 32'(ret_mismatch), 0);

    // Overflow: five pushes into four entries, then five pops.
    redir(32'h0050_0000);
    for (int k = 1; k <= 5; k++) begin
      jtarget = 26'h014_0000 + 26'(k);
      go(PCM_JAL);
    end
    chk("ovf_cnt", 32'(ras_count), 4);
    chk("ovf_full", 32'(ras_full), 1);
    rs_val = 32'h0060_0000;
    go(PCM_RET); chk("pop1", pc, 32'h0050_0014);
    go(PCM_RET); chk("pop2", pc, 32'h0050_0010);
    go(PCM_RET); chk("pop3", pc, 32'h0050_000C);
    go(PCM_RET); chk("pop4", pc, 32'h0050_0008); chk("pop4_cnt", 32'(ras_count), 0);
    go(PCM_RET); chk("pop5", pc, 32'h0060_0000); chk("pop5_nomm", 32'(ret_mismatch), 0);

    // Stall freeze, then redirect over RET.
    redir(32'h0070_0000);
    jtarget = 26'h01C_0010;
    go(PCM_JAL); chk("jal3_pc", pc, 32'h0070_0040);
    stall = 1; mode = PCM_JAL;
    repeat (3) tick();
    mode = PCM_RET;
    tick();
    chk("stall_pc", pc, 32'h0070_0040); chk("stall_cnt", 32'(ras_count), 1);
    stall = 0;
    redirect = 1; redirect_pc = 32'h8000_0180; mode = PCM_RET;
    tick();
    redirect = 0;
    chk("redir_pc", pc, 32'h8000_0180); chk("redir_cnt", 32'(ras_count), 1);

    // Illegal modes, JR, J.
    go(3'd6); chk("ill_pc", pc, 32'h8000_0184); chk("ill_pulse", 32'(illegal_mode), 1);
    go(3'd7); chk("ill7_pulse", 32'(illegal_mode), 1);
    rs_val = 32'h0000_1003;
    go(PCM_JR); chk("jr_pc", pc, 32'h0000_1003); chk("ill_drop", 32'(illegal_mode), 0);
    jtarget = 26'h000_0100;
    go(PCM_J); chk("j_pc", pc, 32'h0000_0400);

    // Reset overrides stall and redirect in the same edge.
    rst_n = 0; stall = 1; redirect = 1; redirect_pc = 32'hDEAD_BEE0; mode = PCM_RET;
    tick();
    chk("rst_mid_pc", pc, 32'h0040_0020); chk("rst_mid_cnt", 32'(ras_count), 0);
    rst_n = 1; stall = 0; redirect = 0;
    go(PCM_SEQ);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
